// File: rtl/activity_led_bank_pkg.sv
// activity_led_pkg: shared types and constants for the activity LED bank.
// Provides the per-channel display mode encoding and the default hold length
// (~50 ms at 90 MHz) used to size the hold counters.
package activity_led_pkg;

    typedef enum logic [1:0] {
        LM_OFF     = 2'd0,
        LM_STRETCH = 2'd1,
        LM_BLINK   = 2'd2,
        LM_FORCE   = 2'd3
    } led_mode_t;

    localparam int unsigned DEF_HOLD_CYCLES = 4500000;

endpackage

// File: rtl/activity_led_bank_if.sv
// activity_led_bank_if: groups the activity inputs, configuration and LED outputs.
// master: the requester side (drives activity/config, observes LEDs).
// slave : the LED bank itself (consumes activity/config, drives LEDs).
interface activity_led_bank_if #(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 23
);
    localparam int AW = $clog2(NUM_CH + 1);

    logic [NUM_CH-1:0]   act_in;
    logic [CNT_W-1:0]    hold_cycles;
    logic [2*NUM_CH-1:0] mode;
    logic [NUM_CH-1:0]   led_out;
    logic                led_any;
    logic [AW-1:0]       active_cnt;

    modport master (
        output act_in, hold_cycles, mode,
        input  led_out, led_any, active_cnt
    );

    modport slave (
        input  act_in, hold_cycles, mode,
        output led_out, led_any, active_cnt
    );

endinterface

// File: rtl/activity_led_bank_chan.sv
// activity_led_chan: one LED channel - hold counter plus mode decode.
// Ports: clk_i/rst_i, act_i activity, hold_i stretch length, mode_i, blink_ph_i,
//        gate_i (brightness gate), busy_d_o/led_raw_d_o next-state flags, led_o LED.
// Latency: LED follows a sampled activity bit after one edge; no backpressure.
module activity_led_chan
    import activity_led_pkg::*;
#(
    parameter int CNT_W = 23
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             act_i,
    input  logic [CNT_W-1:0] hold_i,
    input  led_mode_t        mode_i,
    input  logic             blink_ph_i,
    input  logic             gate_i,
    output logic             busy_d_o,
    output logic             led_raw_d_o,
    output logic             led_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             led_q, led_d;
    logic             busy_d;
    logic             led_raw_d;

    always_comb begin
        // busy looks at the counter before this edge's load/decrement, which
        // gives the one-cycle latency and an exactly-H-cycle high pulse.
        busy_d = (cnt_q != '0);

        cnt_d = cnt_q;
        if (act_i) begin
            cnt_d = (hold_i == '0) ? CNT_W'(1) : hold_i;
        end else if (busy_d) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        led_raw_d = 1'b0;
        case (mode_i)
            LM_OFF:     led_raw_d = 1'b0;
            LM_STRETCH: led_raw_d = busy_d;
            LM_BLINK:   led_raw_d = busy_d & blink_ph_i;
            LM_FORCE:   led_raw_d = 1'b1;
            default:    led_raw_d = 1'b0;
        endcase

        led_d = led_raw_d & gate_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            led_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            led_q <= led_d;
        end
    end

    assign busy_d_o    = busy_d;
    assign led_raw_d_o = led_raw_d;
    assign led_o       = led_q;

endmodule

// File: rtl/activity_led_bank.sv
// activity_led_bank: stretches short activity pulses into visible LED pulses per channel.
// Ports: clk_sys, reset (sync, active-high), bus (activity_led_bank_if.slave),
//        brightness[3:0] only when ACTIVITY_LED_PWM_EN is defined (PWM dimming of led_out).
// Latency: one edge from act_in to led_out/led_any/active_cnt; no backpressure.
module activity_led_bank
    import activity_led_pkg::*;
#(
    parameter int NUM_CH     = 8,
    parameter int CNT_W      = 23,
    parameter int BLINK_HALF = 2250000
) (
    input  logic clk_sys,
    input  logic reset,
`ifdef ACTIVITY_LED_PWM_EN
    input  logic [3:0] brightness,
`endif
    activity_led_bank_if.slave bus
);

    localparam int AW = $clog2(NUM_CH + 1);
    localparam int PW = $clog2(BLINK_HALF + 1);

    // Blink prescaler, shared so that all blinking channels stay in phase.
    logic [PW-1:0] pre_q, pre_d;
    logic          blink_ph_q, blink_ph_d;

    logic [NUM_CH-1:0] busy_d;
    logic [NUM_CH-1:0] led_raw_d;
    logic [NUM_CH-1:0] led_q;
    logic              led_any_q, led_any_d;
    logic [AW-1:0]     act_cnt_q, act_cnt_d;
    logic              gate;

`ifdef ACTIVITY_LED_PWM_EN
    logic [3:0] pwm_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pwm_q <= 4'd0;
        end else begin
            pwm_q <= pwm_q + 4'd1;
        end
    end

    // Duty is (brightness+1)/16; brightness 15 keeps the gate open permanently.
    assign gate = (pwm_q <= brightness);
`else
    assign gate = 1'b1;
`endif

    always_comb begin
        pre_d      = pre_q + PW'(1);
        blink_ph_d = blink_ph_q;
        if (pre_q == PW'(BLINK_HALF - 1)) begin
            pre_d      = '0;
            blink_ph_d = ~blink_ph_q;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        activity_led_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk_i       (clk_sys),
            .rst_i       (reset),
            .act_i       (bus.act_in[i]),
            .hold_i      (bus.hold_cycles),
            .mode_i      (led_mode_t'(bus.mode[2*i +: 2])),
            .blink_ph_i  (blink_ph_q),
            .gate_i      (gate),
            .busy_d_o    (busy_d[i]),
            .led_raw_d_o (led_raw_d[i]),
            .led_o       (led_q[i])
        );
    end

    // Aggregates are built from next-state values so they move on the same
    // edge as led_out; the PWM gate is deliberately left out of both.
    always_comb begin
        led_any_d = |led_raw_d;
        act_cnt_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            act_cnt_d = act_cnt_d + AW'(busy_d[i]);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pre_q      <= '0;
            blink_ph_q <= 1'b0;
            led_any_q  <= 1'b0;
            act_cnt_q  <= '0;
        end else begin
            pre_q      <= pre_d;
            blink_ph_q <= blink_ph_d;
            led_any_q  <= led_any_d;
            act_cnt_q  <= act_cnt_d;
        end
    end

    assign bus.led_out    = led_q;
    assign bus.led_any    = led_any_q;
    assign bus.active_cnt = act_cnt_q;

endmodule

// File: tb/tb_activity_led_bank.sv
// tb_activity_led_bank: directed-vector bench for activity_led_bank.
// 4 channels, 8-bit hold counter, blink half-period of 4 cycles.
// Inputs change 1 time unit after each rising edge; outputs are checked there.
module tb_activity_led_bank;

    logic clk_sys = 1'b0;
    logic reset;
`ifdef ACTIVITY_LED_PWM_EN
    logic [3:0] brightness;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_sys = ~clk_sys;

    activity_led_bank_if #(.NUM_CH(4), .CNT_W(8)) bus ();

    activity_led_bank #(
        .NUM_CH     (4),
        .CNT_W      (8),
        .BLINK_HALF (4)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
`ifdef ACTIVITY_LED_PWM_EN
        .brightness (brightness),
`endif
        .bus        (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Drives ch0 (stretch) with the activity bit pattern act_m, one bit per
    // edge, and compares led_out[0]/led_any/active_cnt to exp_m after each edge.
    task automatic run_seq(input string tag, input logic [7:0] h,
                           input logic [15:0] act_m, input logic [15:0] exp_m, input int n);
        bus.hold_cycles = h;
        bus.mode        = 8'h01;
        for (int c = 0; c < n; c++) begin
            bus.act_in = {3'b000, act_m[c]};
            tick();
            chk({tag, "_led"}, bus.led_out,    {31'd0, exp_m[c]});
            chk({tag, "_any"}, bus.led_any,    {31'd0, exp_m[c]});
            chk({tag, "_cnt"}, bus.active_cnt, {31'd0, exp_m[c]});
        end
        bus.act_in = 4'h0;
    endtask

    initial begin
        logic exp_blink;
        reset           = 1'b1;
        bus.act_in      = 4'hF;
        bus.hold_cycles = 8'd10;
        bus.mode        = 8'h55;
`ifdef ACTIVITY_LED_PWM_EN
        brightness      = 4'd15;
`endif

        // Reset held with all activity high: nothing may light up.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_led", bus.led_out,    32'h0);
            chk("rst_any", bus.led_any,    32'h0);
            chk("rst_cnt", bus.active_cnt, 32'h0);
        end
        reset = 1'b0;
        tick();
        chk("rel_e1_led", bus.led_out, 32'h0);
        tick();
        chk("rel_e2_led", bus.led_out,    32'hF);
        chk("rel_e2_any", bus.led_any,    32'h1);
        chk("rel_e2_cnt", bus.active_cnt, 32'h4);

        // Reset mid-stretch clears everything even with activity present.
        reset = 1'b1;
        tick();
        chk("midrst_led", bus.led_out,    32'h0);
        chk("midrst_cnt", bus.active_cnt, 32'h0);
        reset      = 1'b0;
        bus.act_in = 4'h0;
        tick();
        chk("postrst_led", bus.led_out, 32'h0);

        // tag, hold, activity pattern, expected LED pattern, cycles
        run_seq("single_h5", 8'd5, 16'h0001, 16'h003E, 8);
        run_seq("retrig_h5", 8'd5, 16'h0011, 16'h03FE, 12);
        run_seq("hold0",     8'd0, 16'h0001, 16'h0002, 4);
        run_seq("hold1",     8'd1, 16'h0001, 16'h0002, 4);
        run_seq("reload_h3", 8'd3, 16'h0009, 16'h007E, 9);

        // Mixed modes: ch0 off, ch1 blink, ch2 force-on, ch3 off (active).
        bus.mode        = 8'h38;
        bus.hold_cycles = 8'd2;
        bus.act_in      = 4'b1010;
        reset           = 1'b1;
        tick();
        reset = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            tick();
            exp_blink = (e >= 2) && ((((e - 1) / 4) % 2) == 1);
            chk("mix_led", bus.led_out,    {28'd0, 2'b01, exp_blink, 1'b0});
            chk("mix_any", bus.led_any,    32'h1);
            chk("mix_cnt", bus.active_cnt, (e == 1) ? 32'd0 : 32'd2);
        end

        // Switching ch3 to stretch exposes its still-running counter.
        bus.act_in = 4'h0;
        bus.mode   = 8'h78;
        tick();
        chk("modechg_ch3", bus.led_out[3], 32'h1);

`ifdef ACTIVITY_LED_PWM_EN
        bus.mode   = 8'h03;
        bus.act_in = 4'h0;
        brightness = 4'd3;
        reset      = 1'b1;
        tick();
        reset = 1'b0;
        for (int e = 1; e <= 32; e++) begin
            tick();
            chk("pwm3_led", bus.led_out, (((e - 1) % 16) <= 3) ? 32'h1 : 32'h0);
            chk("pwm3_any", bus.led_any, 32'h1);
        end
        brightness = 4'd15;
        tick();
        for (int e = 0; e < 16; e++) begin
            tick();
            chk("pwm15_led", bus.led_out, 32'h1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
